// File: rtl/trn_mwr_sink_pkg.sv
// Shared constants and helpers for the TRN Memory Write sink.
// Header decode values, trem encodings, FSM state codes and saturating counters.
package trn_mwr_sink_pkg;

    // {fmt, type} of Memory Write with 3DW and 4DW headers
    localparam logic [6:0] FmtTypeMwr32 = 7'b10_00000;
    localparam logic [6:0] FmtTypeMwr64 = 7'b11_00000;

    localparam logic [7:0] TremBoth  = 8'h00;
    localparam logic [7:0] TremUpper = 8'h0F;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHdr2 = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StDrop = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trn_mwr_realign.sv
// Payload lane alignment for the TRN MWr sink: holding DW for 3DW headers,
// pass-through for 4DW headers, and the single-DW flush after end of TLP.
module trn_mwr_realign
    import trn_mwr_sink_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_4dw_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic              hold_v_i,
    input  logic              beat_i,
    input  logic [63:0]       td_i,
    input  logic              en_hi_i,
    input  logic              en_lo_i,
    input  logic              eof_ok_i,
    input  logic              drop_i,
    output logic [1:0]        mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [63:0]       mem_dat_o
);

    logic              mode_q;
    logic [MEM_AW-1:0] waddr_q;
    logic [31:0]       hold_q;
    logic              hold_v_q;
    logic              flush_q;
    logic [1:0]        we_q;
    logic [MEM_AW-1:0] addr_q;
    logic [63:0]       dat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mode_q   <= 1'b0;
            waddr_q  <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            flush_q  <= 1'b0;
            we_q     <= 2'b00;
            addr_q   <= '0;
            dat_q    <= '0;
        end else begin
            we_q <= 2'b00;
            // The cycle after eof never carries a payload beat, so the flush has the port to itself
            if (flush_q) begin
                we_q     <= 2'b10;
                addr_q   <= waddr_q;
                dat_q    <= {hold_q, 32'h0};
                flush_q  <= 1'b0;
                hold_v_q <= 1'b0;
            end
            if (start_i) begin
                mode_q   <= mode_4dw_i;
                waddr_q  <= addr_i;
                hold_q   <= td_i[31:0];
                hold_v_q <= hold_v_i;
                flush_q  <= eof_ok_i && hold_v_i;
            end
            if (beat_i) begin
                addr_q  <= waddr_q;
                waddr_q <= waddr_q + MEM_AW'(2);
                if (mode_q) begin
                    we_q  <= {en_hi_i, en_lo_i};
                    dat_q <= td_i;
                end else begin
                    we_q     <= {hold_v_q, en_hi_i};
                    dat_q    <= {hold_q, td_i[63:32]};
                    hold_q   <= td_i[31:0];
                    hold_v_q <= en_lo_i;
                    flush_q  <= eof_ok_i && en_lo_i;
                end
            end
            if (drop_i) begin
                hold_v_q <= 1'b0;
                flush_q  <= 1'b0;
            end
        end
    end

    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_dat_o  = dat_q;

endmodule

// File: rtl/trn_mwr_sink.sv
// TRN 64-bit transmit sink: decodes MWr TLPs into a DW write port with TLP/drop/error counters.
// Define TRN_MWR_SINK_THROTTLE_EN for LFSR-driven backpressure on trn_tdst_rdy_n.
module trn_mwr_sink
    import trn_mwr_sink_pkg::*;
#(
    parameter int unsigned MEM_AW   = 10,
    parameter logic [31:0] WIN_BASE = 32'h0000_0000
) (
    input  logic              trn_clk,
    input  logic              trn_reset_n,
    input  logic [63:0]       trn_td,
    input  logic [7:0]        trn_trem_n,
    input  logic              trn_tsof_n,
    input  logic              trn_teof_n,
    input  logic              trn_tsrc_rdy_n,
    input  logic              trn_tsrc_dsc_n,
    output logic              trn_tdst_rdy_n,
    output logic              trn_tdst_dsc_n,
    output logic [1:0]        mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [63:0]       mem_dat_o,
    output logic [31:0]       tlp_cnt_o,
    output logic [15:0]       drop_cnt_o,
    output logic              err_o,
    output logic [15:0]       err_cnt_o
);

    logic [1:0]  state_q, state_d;
    logic        is4dw_q, is4dw_d;
    logic [9:0]  len_q, len_d;
    logic [10:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic [31:0] tlp_cnt_q, tlp_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_q, err_d;
    logic        run_q;

    logic        acc, dsc, sof, eof, is_mwr;
    logic [10:0] len_eff;
    logic [29:0] hdr_dw;
    logic        hi_nz, in_win;
    logic [31:0] win_end;
    logic        trem_one, trem_bad;
    logic [1:0]  beat_dws;
    logic        en_hi, en_lo, ovf_now;
    logic [10:0] rem_after;
    logic        hdr_eof_ok, hdr_hold_v;
    logic        rl_start, rl_beat, rl_eof_ok, rl_drop, rl_hold_v;

`ifdef TRN_MWR_SINK_THROTTLE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign trn_tdst_rdy_n = !run_q || (lfsr_q[1:0] == 2'b00);
`else
    assign trn_tdst_rdy_n = !run_q;
`endif

    assign trn_tdst_dsc_n = 1'b1;

    assign acc    = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    assign dsc    = !trn_tsrc_dsc_n;
    assign sof    = !trn_tsof_n;
    assign eof    = !trn_teof_n;
    assign is_mwr = (trn_td[62:56] == FmtTypeMwr32) || (trn_td[62:56] == FmtTypeMwr64);

    // A length field of 0 encodes 1024 DWs
    assign len_eff = {len_q == 10'd0, len_q};
    assign hdr_dw  = is4dw_q ? trn_td[31:2] : trn_td[63:34];
    assign hi_nz   = is4dw_q && (trn_td[63:32] != 32'h0);
    assign win_end = 32'(hdr_dw[MEM_AW-1:0]) + 32'(len_eff);
    assign in_win  = (hdr_dw[29:MEM_AW] == WIN_BASE[31:MEM_AW+2]) &&
                     (win_end <= (32'd1 << MEM_AW));

    assign trem_one  = (trn_trem_n == TremUpper);
    assign trem_bad  = eof && !(trem_one || (trn_trem_n == TremBoth));
    assign beat_dws  = (eof && trem_one) ? 2'd1 : 2'd2;
    assign en_hi     = (rem_q != 11'd0);
    assign en_lo     = (beat_dws == 2'd2) && (rem_q >= 11'd2);
    assign ovf_now   = ovf_q || ({9'd0, beat_dws} > rem_q);
    assign rem_after = rem_q - 11'(en_hi) - 11'(en_lo);

    assign hdr_eof_ok = !is4dw_q && (trn_trem_n == TremBoth) && (len_eff == 11'd1);
    assign hdr_hold_v = !is4dw_q && !(eof && trem_one);

    always_comb begin
        state_d    = state_q;
        is4dw_d    = is4dw_q;
        len_d      = len_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        tlp_cnt_d  = tlp_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_d      = err_q;
        rl_start   = 1'b0;
        rl_beat    = 1'b0;
        rl_eof_ok  = 1'b0;
        rl_drop    = 1'b0;
        rl_hold_v  = 1'b0;
        // Discontinue aborts on any cycle, even when no beat is accepted
        if (dsc) begin
            state_d    = StIdle;
            rl_drop    = 1'b1;
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end else if (acc) begin
            case (state_q)
                StIdle: begin
                    if (!sof || eof) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc16(err_cnt_q);
                    end else begin
                        is4dw_d = trn_td[61];
                        len_d   = trn_td[41:32];
                        state_d = is_mwr ? StHdr2 : StDrop;
                    end
                end
                StHdr2: begin
                    if (hi_nz || !in_win) begin
                        if (eof) begin
                            state_d    = StIdle;
                            drop_cnt_d = sat_inc16(drop_cnt_q);
                        end else begin
                            state_d = StDrop;
                        end
                    end else begin
                        rl_start  = 1'b1;
                        rl_hold_v = hdr_hold_v;
                        rem_d     = is4dw_q ? len_eff : len_eff - 11'd1;
                        ovf_d     = 1'b0;
                        if (eof) begin
                            state_d = StIdle;
                            if (hdr_eof_ok) begin
                                rl_eof_ok = 1'b1;
                                tlp_cnt_d = tlp_cnt_q + 32'd1;
                            end else begin
                                rl_drop   = 1'b1;
                                err_d     = 1'b1;
                                err_cnt_d = sat_inc16(err_cnt_q);
                            end
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    rl_beat = 1'b1;
                    rem_d   = rem_after;
                    ovf_d   = ovf_now;
                    if (eof) begin
                        state_d = StIdle;
                        if (!ovf_now && (rem_after == 11'd0) && !trem_bad) begin
                            rl_eof_ok = 1'b1;
                            tlp_cnt_d = tlp_cnt_q + 32'd1;
                        end else begin
                            rl_drop   = 1'b1;
                            err_d     = 1'b1;
                            err_cnt_d = sat_inc16(err_cnt_q);
                        end
                    end
                end
                default: begin
                    if (eof) begin
                        state_d    = StIdle;
                        drop_cnt_d = sat_inc16(drop_cnt_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            state_q    <= StIdle;
            is4dw_q    <= 1'b0;
            len_q      <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            tlp_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is4dw_q    <= is4dw_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
            tlp_cnt_q  <= tlp_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
            run_q      <= 1'b1;
        end
    end

    trn_mwr_realign #(
        .MEM_AW(MEM_AW)
    ) u_realign (
        .clk_i      (trn_clk),
        .rst_ni     (trn_reset_n),
        .start_i    (rl_start),
        .mode_4dw_i (is4dw_q),
        .addr_i     (hdr_dw[MEM_AW-1:0]),
        .hold_v_i   (rl_hold_v),
        .beat_i     (rl_beat),
        .td_i       (trn_td),
        .en_hi_i    (en_hi),
        .en_lo_i    (en_lo),
        .eof_ok_i   (rl_eof_ok),
        .drop_i     (rl_drop),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_dat_o  (mem_dat_o)
    );

    assign tlp_cnt_o  = tlp_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: doc/trn_mwr_sink.md
Name: trn_mwr_sink

Overview:
- Destination end of the 64-bit TRN transmit interface driven by the bus master DMA engine.
- Accepts the TLP stream that the DMA engine sources, decodes Memory Write TLPs with 3DW or 4DW headers, and realigns the payload to DW addresses.
- Drives a 64-bit dual-DW write port into a local buffer, and keeps TLP, drop and error counters.
- Used as a loopback sink in system simulation and as the on-chip DMA capture target for sniffer self-test.

Parameters:
MEM_AW, 10, DW address width of the write port; the window is 2^MEM_AW DWs.
WIN_BASE, 32'h0000_0000, byte base address of the accepted window; must be aligned to 2^(MEM_AW+2) bytes.

Ports:
trn_clk  in  1  clock
trn_reset_n  in  1  synchronous active-low reset
trn_td  in  64  TLP data; DW0 in [63:32], DW1 in [31:0]
trn_trem_n  in  8  8'h00 = both DWs valid; 8'h0F = only [63:32] valid (meaningful only with trn_teof_n)
trn_tsof_n  in  1  start of TLP
trn_teof_n  in  1  end of TLP
trn_tsrc_rdy_n  in  1  source ready
trn_tsrc_dsc_n  in  1  source discontinue
trn_tdst_rdy_n  out  1  destination ready
trn_tdst_dsc_n  out  1  destination discontinue; constant 1
mem_we_o  out  2  bit1 = write DW at mem_addr_o; bit0 = write DW at mem_addr_o+1
mem_addr_o  out  MEM_AW  DW address of the upper lane
mem_dat_o  out  64  [63:32] goes to mem_addr_o; [31:0] goes to mem_addr_o+1
tlp_cnt_o  out  32  count of MWr TLPs completed without error
drop_cnt_o  out  16  count of TLPs dropped (non-MWr, out-of-window, discontinued); saturates
err_o  out  1  sticky malformed-TLP flag
err_cnt_o  out  16  count of malformed TLPs; saturates

Behaviour:
- Beat accepted when trn_tsrc_rdy_n == 0 and trn_tdst_rdy_n == 0. All state advances only on accepted beats, except the flush cycle.
- Reset values: all outputs 0, except trn_tdst_rdy_n = 1 and trn_tdst_dsc_n = 1. trn_tdst_rdy_n goes to 0 on the first cycle after reset is released.
- Reset mid-TLP: state returns to IDLE and the holding DW is discarded.
- FSM states: IDLE, HDR2, DATA, DROP.
- IDLE:
  - An accepted beat without sof sets err_o and increments err_cnt_o; state stays IDLE.
  - On sof, latch fmt = td[62:61], type = td[60:56], len = td[41:32] (len 0 means 1024).
  - MWr is fmt[1] == 1 and type == 0. MWr goes to HDR2; anything else goes to DROP.
  - sof together with eof is malformed (err); state stays IDLE.
- HDR2, 3DW header (fmt[0] == 0):
  - addr = {td[63:34], 2'b00}.
  - td[31:0] is the first payload DW; it goes to the holding register.
- HDR2, 4DW header: addr = {td[31:2], 2'b00}; td[63:32] must be 0, otherwise drop.
- Window check in HDR2: start..start+len-1 must lie fully inside the window, otherwise the whole TLP is dropped (DROP, or IDLE if eof). There is no wrap-around within the window.
- DATA, 4DW header: data is already aligned. mem_we_o is registered 1 cycle after acceptance; the address increments by 2 per full beat.
- DATA, 3DW header (realigned): each beat emits {hold, td[63:32]}, then hold <= td[31:0]. Output lags acceptance by 1 cycle.
- Flush: on eof, a leftover held DW is written in the following cycle with mem_we_o = 2'b10.
  - Back-to-back TLPs are accepted with no gap: the next TLP's first beat is a header and produces no write, so it never conflicts with the flush.
- Odd length: the last beat carries one DW. It is valid only with trn_trem_n == 8'h0F at eof.
- Length check at eof: received DW count must equal len.
  - Mismatch: err_o set, err_cnt_o incremented, tlp_cnt_o not incremented.
  - Writes already issued stand; the remaining held DW is discarded.
  - Data beyond len is never written.
- trn_tsrc_dsc_n == 0 in any state: abort to IDLE, discard hold, increment drop_cnt_o.
- DROP: consume beats until eof, then return to IDLE and increment drop_cnt_o.
- Counters: tlp_cnt_o wraps; drop_cnt_o and err_cnt_o saturate at 16'hFFFF.

Optional Feature:
- Macro: TRN_MWR_SINK_THROTTLE_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reset to the seed) forces trn_tdst_rdy_n = 1 whenever lfsr[1:0] == 2'b00, giving about 25% backpressure for bench stress.
- Not defined: trn_tdst_rdy_n is 0 continuously after reset.
- Functional results are identical either way; only timing differs.

Decomposition:
- Shared package:
  - fmt/type constants (MWR32 = 7'b10_00000, MWR64 = 7'b11_00000).
  - trem encodings 8'h00 / 8'h0F.
  - FSM state enum.
  - saturating-increment function.
- Sub-module trn_mwr_realign: holding register plus 3DW/4DW lane alignment and eof flush. Counters and FSM stay in the top.

Test Plan:
- 3DW MWr, len 4, addr 0x10, data 1..4 -> writes {1,2}@4 then {3,4}@6, we=2'b11 each; tlp_cnt_o=1.
- 4DW MWr, len 3, addr hi 0 / lo 0x20, trem 8'h0F at eof -> {1,2}@8 we=11, {3,x}@10 we=10; tlp_cnt_o=1.
- 3DW MWr, len 5, eof one beat early -> err_o=1, err_cnt_o=1, no write past the received data, tlp_cnt_o unchanged.
- Memory read TLP (fmt 00) followed back-to-back by a valid MWr -> drop_cnt_o=1, MWr written correctly with no gap cycle.
- MWr to WIN_BASE+0x1000 (MEM_AW=10) -> no writes, drop_cnt_o=1; trn_tsrc_dsc_n pulsed mid-TLP -> IDLE, drop_cnt_o=2.
- Reset asserted mid-TLP, then a clean len-2 3DW MWr -> no stale flush, single write we=11; repeat with TRN_MWR_SINK_THROTTLE_EN defined -> identical memory contents.
